fsmc_master: RTL

Initiator side of the team's multiplexed FSMC bus: it issues single read and write transactions on the 18-bit address/data bus using the NADV/NWE/NOE strobes, with programmable phase lengths. It is the counterpart of the FPGA-side FSMC responder. It is used to exercise that responder on-chip, and to link two FPGAs where this device plays the MCU role. A simple valid/ready request port and a one-cycle response pulse connect it to internal logic.

---
 rtl/fsmc_master.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fsmc_master.sv
// rtl/fsmc_master.sv - multiplexed FSMC bus initiator with programmable phase lengths
// Optional: FSMC_MASTER_DEBUG_EN adds debug_state / debug_count outputs.
module fsmc_master #(
    parameter int ADDSET  = 4,
    parameter int ADDHLD  = 4,
    parameter int DATAST  = 8,
    parameter int BUSTURN = 3
) (
    input  logic        clk,
    input  logic        reset,
    inout  wire  [17:0] AD,
    output logic        NE,
    output logic        NADV,
    output logic        NWE,
    output logic        NOE,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [17:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata
`ifdef FSMC_MASTER_DEBUG_EN
    ,
    output logic [3:0]  debug_state,
    output logic [15:0] debug_count
`endif
);

    if (ADDSET < 1 || ADDSET > 255 || ADDHLD < 1 || ADDHLD > 255 ||
        DATAST < 1 || DATAST > 255 || BUSTURN < 1 || BUSTURN > 255) begin : g_bad_param
        $error("fsmc_master: phase lengths must be in 1..255");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_AHOLD,
        S_DATA,
        S_TURN
    } state_t;

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic        accept;
    logic        last;

    logic        wr_q;
    logic [17:0] addr_q;
    logic [15:0] wdata_q;

    logic        ne_n, nadv_n, nwe_n, noe_n, oe_n;
    logic [17:0] ad_n;
    logic        ad_oe;
    logic [17:0] ad_q;

    assign last      = (cnt == 8'd1);
    assign req_ready = (state == S_IDLE);
    assign AD        = ad_oe ? ad_q : 18'bz;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    state_n = S_ADDR;
                    cnt_n   = 8'(ADDSET);
                end
            end
            S_ADDR: begin
                if (last) begin
                    state_n = S_AHOLD;
                    cnt_n   = 8'(ADDHLD);
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_AHOLD: begin
                if (last) begin
                    state_n = S_DATA;
                    cnt_n   = 8'(DATAST);
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_DATA: begin
                if (last) begin
                    state_n = S_TURN;
                    cnt_n   = 8'(BUSTURN);
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            S_TURN: begin
                if (last) begin
                    state_n = S_IDLE;
                    cnt_n   = 8'd0;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = 8'd0;
            end
        endcase
    end

    // Pin values are decoded from the next state so every pin comes straight off a flop.
    always_comb begin
        ne_n   = 1'b1;
        nadv_n = 1'b1;
        nwe_n  = 1'b1;
        noe_n  = 1'b1;
        oe_n   = 1'b0;
        ad_n   = ad_q;
        case (state_n)
            S_ADDR: begin
                ne_n   = 1'b0;
                nadv_n = 1'b0;
                oe_n   = 1'b1;
                ad_n   = accept ? req_addr : addr_q;
            end
            S_AHOLD: begin
                ne_n = 1'b0;
                oe_n = 1'b1;
                ad_n = addr_q;
            end
            S_DATA: begin
                ne_n = 1'b0;
                if (wr_q) begin
                    nwe_n = 1'b0;
                    oe_n  = 1'b1;
                    ad_n  = {2'b00, wdata_q};
                end else begin
                    noe_n = 1'b0;
                end
            end
            S_TURN: begin
                // Writes keep data on the bus so the responder's delayed capture still sees it.
                oe_n = wr_q;
            end
            default: begin
                oe_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            wr_q      <= 1'b0;
            addr_q    <= 18'd0;
            wdata_q   <= 16'd0;
            NE        <= 1'b1;
            NADV      <= 1'b1;
            NWE       <= 1'b1;
            NOE       <= 1'b1;
            ad_oe     <= 1'b0;
            ad_q      <= 18'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 16'd0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            NE        <= ne_n;
            NADV      <= nadv_n;
            NWE       <= nwe_n;
            NOE       <= noe_n;
            ad_oe     <= oe_n;
            ad_q      <= ad_n;
            rsp_valid <= (state == S_TURN) && last;
            if (accept) begin
                wr_q    <= req_write;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if ((state == S_DATA) && last && !wr_q) begin
                rsp_rdata <= AD[15:0];
            end
        end
    end

`ifdef FSMC_MASTER_DEBUG_EN
    always_comb begin
        debug_state = 4'b0000;
        case (state)
            S_ADDR:  debug_state = 4'b0001;
            S_AHOLD: debug_state = 4'b0010;
            S_DATA:  debug_state = 4'b0100;
            S_TURN:  debug_state = 4'b1000;
            default: debug_state = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            debug_count <= 16'd0;
        end else if (rsp_valid && (debug_count != 16'hFFFF)) begin
            debug_count <= debug_count + 16'd1;
        end
    end
`endif

endmodule
